// File: rtl/clkgen_multi_if.sv
// Run/sync/config inputs and per-channel divided-clock outputs of clkgen_multi.
interface clkgen_multi_if #(
  parameter int unsigned NCH = 4,
  parameter int unsigned CW  = 25,
  parameter int unsigned CHW = (NCH > 1) ? $clog2(NCH) : 1
);
  logic [NCH-1:0] en_i;
  logic           sync_i;
  logic           cfg_we_i;
  logic [CHW-1:0] cfg_ch_i;
  logic [CW-1:0]  cfg_div_i;
  logic [NCH-1:0] clk_o;
  logic [NCH-1:0] tick_o;
  logic [NCH-1:0] pend_o;
  logic [NCH-1:0] run_o;

  modport master (
    output en_i, sync_i, cfg_we_i, cfg_ch_i, cfg_div_i,
    input  clk_o, tick_o, pend_o, run_o
  );

  modport slave (
    input  en_i, sync_i, cfg_we_i, cfg_ch_i, cfg_div_i,
    output clk_o, tick_o, pend_o, run_o
  );
endinterface

// File: rtl/clkgen_multi.sv
// Multi-channel programmable clock divider. Each channel toggles clk_o every
// D+1 cycles, stops only after a completed high phase, and picks up new divide
// values at its next reload so no phase is ever truncated or stretched.
// NCH is expected in 1..16.
module clkgen_multi #(
  parameter int unsigned NCH         = 4,
  parameter int unsigned CW          = 25,
  parameter int unsigned DEFAULT_DIV = 0
) (
  input  logic          clk_i,
  input  logic          rst_i,
  clkgen_multi_if.slave bus
);

  localparam int unsigned   CHW     = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [CW-1:0] DIV_RST = CW'(DEFAULT_DIV);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STOP = 2'd2
  } state_e;

  logic [1:0]     rst_sync_q;
  logic           rst_n;
  logic [NCH-1:0] clk_vec;
  logic [NCH-1:0] tick_vec;
  logic [NCH-1:0] pend_vec;
  logic [NCH-1:0] run_vec;

  // Reset synchronizer: assertion is immediate, release is aligned to clk_i.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  assign rst_n = rst_sync_q[1];

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    state_e        state_q, state_d;
    logic [CW-1:0] div_q, div_d;
    logic [CW-1:0] pdiv_q, pdiv_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] div_eff;
    logic          pend_q, pend_d;
    logic          clk_q, clk_d;
    logic          tick_q, tick_d;
    logic          run_q, run_d;
    logic          reload;
    logic          wr_hit;
    logic          en;

    assign en      = bus.en_i[i];
    // Out-of-range channel numbers never match any i, so they are dropped.
    assign wr_hit  = bus.cfg_we_i && (bus.cfg_ch_i == CHW'(i));
    // Divide value a reload would use this cycle.
    assign div_eff = pend_q ? pdiv_q : div_q;

    // Channel state, counter, divide values and registered outputs.
    always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
        state_q <= ST_IDLE;
        div_q   <= DIV_RST;
        pdiv_q  <= DIV_RST;
        cnt_q   <= DIV_RST;
        pend_q  <= 1'b0;
        clk_q   <= 1'b0;
        tick_q  <= 1'b0;
        run_q   <= 1'b0;
      end else begin
        state_q <= state_d;
        div_q   <= div_d;
        pdiv_q  <= pdiv_d;
        cnt_q   <= cnt_d;
        pend_q  <= pend_d;
        clk_q   <= clk_d;
        tick_q  <= tick_d;
        run_q   <= run_d;
      end
    end

    // Next-state: sync beats counting; a stopping channel always finishes high.
    always_comb begin
      state_d = state_q;
      div_d   = div_q;
      pdiv_d  = pdiv_q;
      cnt_d   = cnt_q;
      pend_d  = pend_q;
      clk_d   = clk_q;
      tick_d  = 1'b0;
      reload  = 1'b0;

      case (state_q)
        ST_IDLE: begin
          clk_d = 1'b0;
          if (en) begin
            reload  = 1'b1;
            state_d = ST_RUN;
          end
        end
        ST_RUN: begin
          if (bus.sync_i) begin
            reload  = 1'b1;
            clk_d   = 1'b0;
            state_d = en ? ST_RUN : ST_IDLE;
          end else if (!en && !clk_q) begin
            state_d = ST_IDLE;
          end else if (cnt_q == '0) begin
            // With en low here clk_q is high, so this is the final falling toggle.
            reload  = 1'b1;
            clk_d   = ~clk_q;
            tick_d  = 1'b1;
            state_d = en ? ST_RUN : ST_IDLE;
          end else begin
            cnt_d   = cnt_q - CW'(1);
            state_d = en ? ST_RUN : ST_STOP;
          end
        end
        ST_STOP: begin
          if (bus.sync_i) begin
            reload  = 1'b1;
            clk_d   = 1'b0;
            state_d = ST_IDLE;
          end else if (cnt_q == '0) begin
            reload  = 1'b1;
            clk_d   = ~clk_q;
            tick_d  = 1'b1;
            state_d = en ? ST_RUN : ST_IDLE;
          end else begin
            cnt_d   = cnt_q - CW'(1);
            state_d = en ? ST_RUN : ST_STOP;
          end
        end
        default: begin
          state_d = ST_IDLE;
          clk_d   = 1'b0;
        end
      endcase

      if (reload) begin
        cnt_d  = div_eff;
        div_d  = div_eff;
        pend_d = 1'b0;
      end

      // A write landing on a reload cycle is held over to the next reload.
      if (wr_hit) begin
        if ((state_q == ST_IDLE) && !reload) begin
          div_d  = bus.cfg_div_i;
          pend_d = 1'b0;
        end else begin
          pdiv_d = bus.cfg_div_i;
          pend_d = 1'b1;
        end
      end

      run_d = (state_d != ST_IDLE);
    end

    assign clk_vec[i]  = clk_q;
    assign tick_vec[i] = tick_q;
    assign pend_vec[i] = pend_q;
    assign run_vec[i]  = run_q;
  end

  assign bus.clk_o  = clk_vec;
  assign bus.tick_o = tick_vec;
  assign bus.pend_o = pend_vec;
  assign bus.run_o  = run_vec;

endmodule

// File: tb/tb_clkgen_multi.sv
// Self-checking bench for clkgen_multi: a cycle model feeds a scoreboard queue,
// plus directed timing scenarios and a randomized soak.
module tb_clkgen_multi;

  localparam int unsigned NCH         = 3;
  localparam int unsigned CW          = 8;
  localparam int unsigned DEFAULT_DIV = 1;
  localparam int unsigned CHW         = 2;

  localparam int S_IDLE = 0;
  localparam int S_RUN  = 1;
  localparam int S_STOP = 2;

  typedef struct packed {
    logic [NCH-1:0] clk;
    logic [NCH-1:0] tick;
    logic [NCH-1:0] pend;
    logic [NCH-1:0] run;
  } out_t;

  logic clk_i;
  logic rst_i;

  clkgen_multi_if #(.NCH(NCH), .CW(CW), .CHW(CHW)) bus ();

  clkgen_multi #(
    .NCH         (NCH),
    .CW          (CW),
    .DEFAULT_DIV (DEFAULT_DIV)
  ) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int n_checks;
  int n_errors;
  out_t exp_q[$];

  logic [CW-1:0] m_a   [NCH];
  logic [CW-1:0] m_p   [NCH];
  logic [CW-1:0] m_c   [NCH];
  logic          m_pf  [NCH];
  logic          m_clk [NCH];
  logic          m_tick[NCH];
  int            m_st  [NCH];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_a[i]    = CW'(DEFAULT_DIV);
      m_p[i]    = CW'(DEFAULT_DIV);
      m_c[i]    = CW'(DEFAULT_DIV);
      m_pf[i]   = 1'b0;
      m_clk[i]  = 1'b0;
      m_tick[i] = 1'b0;
      m_st[i]   = S_IDLE;
    end
  endtask

  // One clock of the reference behaviour, from the inputs currently applied.
  task automatic model_step();
    for (int i = 0; i < NCH; i++) begin
      logic [CW-1:0] aeff;
      logic [CW-1:0] c_n;
      logic          rl;
      logic          tk;
      logic          ck;
      logic          en_b;
      logic          hit;
      int            nst;
      aeff = m_pf[i] ? m_p[i] : m_a[i];
      en_b = bus.en_i[i];
      hit  = bus.cfg_we_i && (int'(bus.cfg_ch_i) == i);
      rl   = 1'b0;
      tk   = 1'b0;
      ck   = m_clk[i];
      c_n  = m_c[i];
      nst  = m_st[i];
      if (m_st[i] == S_IDLE) begin
        ck = 1'b0;
        if (en_b) begin rl = 1'b1; nst = S_RUN; end
      end else if (bus.sync_i) begin
        rl  = 1'b1;
        ck  = 1'b0;
        nst = (m_st[i] == S_RUN && en_b) ? S_RUN : S_IDLE;
      end else if (m_st[i] == S_RUN && !en_b && !m_clk[i]) begin
        nst = S_IDLE;
      end else if (m_c[i] == '0) begin
        rl  = 1'b1;
        ck  = ~m_clk[i];
        tk  = 1'b1;
        nst = en_b ? S_RUN : S_IDLE;
      end else begin
        c_n = m_c[i] - CW'(1);
        nst = en_b ? S_RUN : S_STOP;
      end
      if (rl) begin
        c_n     = aeff;
        m_a[i]  = aeff;
        m_pf[i] = 1'b0;
      end
      if (hit) begin
        if (m_st[i] == S_IDLE && !rl) begin
          m_a[i]  = bus.cfg_div_i;
          m_pf[i] = 1'b0;
        end else begin
          m_p[i]  = bus.cfg_div_i;
          m_pf[i] = 1'b1;
        end
      end
      m_c[i]    = c_n;
      m_clk[i]  = ck;
      m_tick[i] = tk;
      m_st[i]   = nst;
    end
  endtask

  function automatic out_t model_out();
    out_t o;
    for (int i = 0; i < NCH; i++) begin
      o.clk[i]  = m_clk[i];
      o.tick[i] = m_tick[i];
      o.pend[i] = m_pf[i];
      o.run[i]  = (m_st[i] != S_IDLE);
    end
    return o;
  endfunction

  // Advance one clock: predict at the edge, compare at the following negedge.
  task automatic cycle();
    out_t e;
    @(posedge clk_i);
    if (!rst_i) model_reset();
    else        model_step();
    exp_q.push_back(model_out());
    @(negedge clk_i);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check_eq("sb_clk",  32'(bus.clk_o),  32'(e.clk));
      check_eq("sb_tick", 32'(bus.tick_o), 32'(e.tick));
      check_eq("sb_pend", 32'(bus.pend_o), 32'(e.pend));
      check_eq("sb_run",  32'(bus.run_o),  32'(e.run));
    end
    bus.sync_i   = 1'b0;
    bus.cfg_we_i = 1'b0;
  endtask

  task automatic cfg_write(input int ch, input int div);
    bus.cfg_we_i  = 1'b1;
    bus.cfg_ch_i  = CHW'(ch);
    bus.cfg_div_i = CW'(div);
    cycle();
  endtask

  // Cycles until tick_o[ch] is seen; returns budget if it never comes.
  task automatic wait_tick(input int ch, input int budget, output int n);
    n = 0;
    while (n < budget) begin
      cycle();
      n++;
      if (bus.tick_o[ch]) break;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int r0;
    int r1;
    int cnt;
    n_checks      = 0;
    n_errors      = 0;
    bus.en_i      = '0;
    bus.sync_i    = 1'b0;
    bus.cfg_we_i  = 1'b0;
    bus.cfg_ch_i  = '0;
    bus.cfg_div_i = '0;
    rst_i         = 1'b1;
    model_reset();
    #1 rst_i = 1'b0;

    // Reset state, then release and let the reset synchronizer settle.
    repeat (2) cycle();
    check_eq("rst_run", 32'(bus.run_o), 32'(0));
    rst_i = 1'b1;
    repeat (3) cycle();

    // Divide-by-5 on ch0 configured while idle.
    cfg_write(0, 4);
    check_eq("idle_wr_pend", 32'(bus.pend_o[0]), 32'(0));
    bus.en_i[0] = 1'b1;
    cycle();
    check_eq("entry_run", 32'(bus.run_o[0]), 32'(1));
    check_eq("entry_clk", 32'(bus.clk_o[0]), 32'(0));
    wait_tick(0, 40, n);
    check_eq("d4_first_rise", 32'(n), 32'(5));
    check_eq("d4_first_level", 32'(bus.clk_o[0]), 32'(1));
    wait_tick(0, 40, n);
    check_eq("d4_high_len", 32'(n), 32'(5));
    wait_tick(0, 40, n);
    check_eq("d4_low_len", 32'(n), 32'(5));

    // ch1 at D=2 switches to D=0 mid-count.
    cfg_write(1, 2);
    bus.en_i[1] = 1'b1;
    cycle();
    wait_tick(1, 40, n);
    check_eq("d2_first_rise", 32'(n), 32'(3));
    cycle();
    cfg_write(1, 0);
    check_eq("mid_wr_pend", 32'(bus.pend_o[1]), 32'(1));
    wait_tick(1, 40, n);
    check_eq("switch_phase_rest", 32'(n), 32'(1));
    check_eq("switch_pend_clr", 32'(bus.pend_o[1]), 32'(0));
    wait_tick(1, 40, n);
    check_eq("d0_gap_a", 32'(n), 32'(1));
    wait_tick(1, 40, n);
    check_eq("d0_gap_b", 32'(n), 32'(1));

    // ch2 at D=3: stop while high, stop while low, re-enable during STOP.
    cfg_write(2, 3);
    bus.en_i[2] = 1'b1;
    cycle();
    wait_tick(2, 40, n);
    check_eq("d3_rise", 32'(n), 32'(4));
    check_eq("d3_rise_lvl", 32'(bus.clk_o[2]), 32'(1));
    bus.en_i[2] = 1'b0;
    wait_tick(2, 40, n);
    check_eq("stop_high_len", 32'(n), 32'(4));
    check_eq("stop_fall_lvl", 32'(bus.clk_o[2]), 32'(0));
    check_eq("stop_idle", 32'(bus.run_o[2]), 32'(0));
    cnt = 0;
    for (int k = 0; k < 8; k++) begin
      cycle();
      if (bus.tick_o[2]) cnt++;
    end
    check_eq("idle_no_tick", 32'(cnt), 32'(0));

    bus.en_i[2] = 1'b1;
    cycle();
    wait_tick(2, 40, n);
    check_eq("low_stop_rise", 32'(n), 32'(4));
    wait_tick(2, 40, n);
    check_eq("low_stop_fall", 32'(n), 32'(4));
    bus.en_i[2] = 1'b0;
    cycle();
    check_eq("low_stop_idle", 32'(bus.run_o[2]), 32'(0));
    check_eq("low_stop_clk", 32'(bus.clk_o[2]), 32'(0));

    bus.en_i[2] = 1'b1;
    cycle();
    wait_tick(2, 40, n);
    bus.en_i[2] = 1'b0;
    cycle();
    cycle();
    check_eq("stop_state_run", 32'(bus.run_o[2]), 32'(1));
    bus.en_i[2] = 1'b1;
    wait_tick(2, 40, n);
    check_eq("stop_rerun_fall", 32'(n), 32'(2));
    wait_tick(2, 40, n);
    check_eq("stop_rerun_rise", 32'(n), 32'(4));
    check_eq("stop_rerun_run", 32'(bus.run_o[2]), 32'(1));

    bus.en_i = '0;
    repeat (12) cycle();
    check_eq("all_drained", 32'(bus.run_o), 32'(0));

    // Sync phase-aligns ch0 (D=1) and ch1 (D=2).
    cfg_write(0, 1);
    cfg_write(1, 2);
    check_eq("sync_cfg_pend", 32'(bus.pend_o), 32'(0));
    bus.en_i = 3'b011;
    repeat (7) cycle();
    bus.sync_i = 1'b1;
    cycle();
    check_eq("sync_clk_low", 32'(bus.clk_o[1:0]), 32'(0));
    check_eq("sync_no_tick", 32'(bus.tick_o[1:0]), 32'(0));
    r0 = 0;
    r1 = 0;
    for (int k = 1; k <= 5; k++) begin
      cycle();
      if (r0 == 0 && bus.clk_o[0]) r0 = k;
      if (r1 == 0 && bus.clk_o[1]) r1 = k;
    end
    check_eq("sync_rise_ch0", 32'(r0), 32'(2));
    check_eq("sync_rise_ch1", 32'(r1), 32'(3));

    // Write to a channel number past NCH changes nothing.
    cfg_write(3, 9);
    check_eq("oor_pend", 32'(bus.pend_o), 32'(0));
    wait_tick(0, 40, n);
    wait_tick(0, 40, n);
    check_eq("oor_ch0_gap", 32'(n), 32'(2));
    wait_tick(1, 40, n);
    wait_tick(1, 40, n);
    check_eq("oor_ch1_gap", 32'(n), 32'(3));

    // Asynchronous reset mid-period with a pending write outstanding.
    cfg_write(0, 7);
    check_eq("pre_rst_pend", 32'(bus.pend_o[0]), 32'(1));
    #2;
    rst_i    = 1'b0;
    bus.en_i = '0;
    #1;
    check_eq("arst_clk",  32'(bus.clk_o),  32'(0));
    check_eq("arst_tick", 32'(bus.tick_o), 32'(0));
    check_eq("arst_pend", 32'(bus.pend_o), 32'(0));
    check_eq("arst_run",  32'(bus.run_o),  32'(0));
    model_reset();
    exp_q.delete();
    repeat (2) cycle();
    rst_i = 1'b1;
    repeat (3) cycle();
    bus.en_i[0] = 1'b1;
    cycle();
    check_eq("post_rst_run", 32'(bus.run_o[0]), 32'(1));
    wait_tick(0, 40, n);
    check_eq("post_rst_rise", 32'(n), 32'(DEFAULT_DIV + 1));
    wait_tick(0, 40, n);
    check_eq("post_rst_gap", 32'(n), 32'(DEFAULT_DIV + 1));
    check_eq("post_rst_pend", 32'(bus.pend_o[0]), 32'(0));

    // Randomized soak, checked by the scoreboard every cycle.
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 7) == 0) bus.en_i = NCH'($urandom);
      bus.sync_i = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 5) == 0) begin
        bus.cfg_we_i  = 1'b1;
        bus.cfg_ch_i  = CHW'($urandom_range(0, 3));
        bus.cfg_div_i = CW'($urandom_range(0, 5));
      end
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
